if_fetch: RTL

Instruction-fetch stage that produces the instruction/PC stream consumed by the `id` decode stage. It owns the program counter, drives a synchronous-read instruction memory, and presents the fetched instruction with its PC and a valid flag on the IF/ID boundary. It honours a hold request from the hazard logic and a redirect (taken branch or jump) from later stages, inserting NOP bubbles as required.

---
 rtl/if_fetch.sv | 84 ++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read imem and issues instr/PC/valid to ID.
// Optional IF_FETCH_PERF_EN adds fetch_count / bubble_count performance counters.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [31:0] fpc, fpc_nx, pc_nx;
    logic        hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= BOOT;
            fpc    <= RESET_PC;
            pc_out <= '0;
        end else begin
            state  <= state_nx;
            fpc    <= fpc_nx;
            pc_out <= pc_nx;
        end
    end

    // Stall only bites while a real instruction is held; a bubble is always overwritten.
    always_comb begin
        hold     = stall && (state == RUN);
        state_nx = state;
        fpc_nx   = fpc;
        pc_nx    = pc_out;
        if (redirect) begin
            state_nx = FLUSH;
            fpc_nx   = redirect_pc;
        end else if (!hold) begin
            state_nx = RUN;
            fpc_nx   = fpc + PC_STEP;
            pc_nx    = fpc;
        end
    end

    always_comb begin
        valid_out = (state == RUN);
        imem_addr = fpc;
        imem_en   = !rst && (redirect || !hold);
        instr_out = valid_out ? imem_rdata : '0;
    end

`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (valid_out && !stall)
                fetch_count <= fetch_count + 32'd1;
            if (!valid_out)
                bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule
